// File: rtl/sine_channel_scheduler.sv
// Two-channel sine sample-rate scheduler: per-channel divider, prescaler and mirrored LUT index,
// with an IDLE/RUN/DRAIN FSM that always lets a stopped waveform finish at index 0.
module sine_channel_scheduler #(
   parameter int unsigned DIV_WIDTH = 16,
   parameter int unsigned IDX_WIDTH = 8
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_i,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic                 cfg_ch_i,
   input  logic [DIV_WIDTH-1:0] cfg_div_i,
   input  logic [1:0]           start_i,
   input  logic [1:0]           stop_i,
   output logic                 sw_clk_1_o,
   output logic                 sw_clk_2_o,
   output logic                 sw_en_1_o,
   output logic                 sw_en_2_o,
   output logic [IDX_WIDTH-1:0] idx_1_o,
   output logic [IDX_WIDTH-1:0] idx_2_o,
   output logic [1:0]           busy_o,
   output logic [1:0]           cycle_done_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]           r_state [2];
   logic [DIV_WIDTH-1:0] r_div   [2];
   logic [DIV_WIDTH-1:0] r_presc [2];
   logic [IDX_WIDTH-1:0] r_idx   [2];
   logic [1:0]           r_swclk;
   logic [1:0]           r_busy;
   logic [1:0]           r_done;

   logic [1:0]           w_state_nx [2];
   logic [1:0]           w_active;
   logic [1:0]           w_tick;
   logic [1:0]           w_wrap;
   logic [1:0]           w_cfg_we;

   always_comb begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
         w_active[ch]   = (r_state[ch] == S_RUN) || (r_state[ch] == S_DRAIN);
         w_tick[ch]     = w_active[ch] && (r_presc[ch] == r_div[ch]);
         w_wrap[ch]     = r_swclk[ch] && (r_idx[ch] == '1);
         w_cfg_we[ch]   = cfg_valid_i && (cfg_ch_i == ch[0]) && (r_state[ch] == S_IDLE);
         w_state_nx[ch] = r_state[ch];
         case (r_state[ch])
            S_IDLE:  if (start_i[ch] && !stop_i[ch]) w_state_nx[ch] = S_RUN;
            S_RUN:   if (stop_i[ch]) w_state_nx[ch] = S_DRAIN;
            // a fresh start cancels the pending stop even on the wrap edge
            S_DRAIN: begin
               if (start_i[ch] && !stop_i[ch]) w_state_nx[ch] = S_RUN;
               else if (w_wrap[ch])            w_state_nx[ch] = S_IDLE;
            end
            default: w_state_nx[ch] = S_IDLE;
         endcase
      end
   end

   assign cfg_ready_o = (r_state[cfg_ch_i] == S_IDLE);

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         for (int unsigned ch = 0; ch < 2; ch++) begin
            r_state[ch] <= S_IDLE;
            r_div[ch]   <= '0;
            r_presc[ch] <= '0;
            r_idx[ch]   <= '0;
         end
         r_swclk <= '0;
         r_busy  <= '0;
         r_done  <= '0;
      end else begin
         for (int unsigned ch = 0; ch < 2; ch++) begin
            r_state[ch] <= w_state_nx[ch];
            if (w_cfg_we[ch]) r_div[ch] <= cfg_div_i;
            // the tick that would coincide with the drain-complete edge is dropped
            if (!w_active[ch] || (w_state_nx[ch] == S_IDLE) || w_tick[ch]) r_presc[ch] <= '0;
            else                                                            r_presc[ch] <= r_presc[ch] + DIV_WIDTH'(1);
            r_swclk[ch] <= w_tick[ch] && (w_state_nx[ch] != S_IDLE);
            if (r_swclk[ch]) r_idx[ch] <= r_idx[ch] + IDX_WIDTH'(1);
            r_done[ch]  <= w_wrap[ch];
            r_busy[ch]  <= w_active[ch];
         end
      end
   end

   assign sw_clk_1_o   = r_swclk[0];
   assign sw_clk_2_o   = r_swclk[1];
   assign sw_en_1_o    = r_busy[0];
   assign sw_en_2_o    = r_busy[1];
   assign idx_1_o      = r_idx[0];
   assign idx_2_o      = r_idx[1];
   assign busy_o       = r_busy;
   assign cycle_done_o = r_done;

endmodule

// File: tb/tb_sine_channel_scheduler.sv
// Randomized bench for sine_channel_scheduler against a modulo-arithmetic reference model.
module tb_sine_channel_scheduler;

   localparam int unsigned DW = 16;
   localparam int unsigned IW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_valid_i = 1'b0;
   logic          cfg_ready_o;
   logic          cfg_ch_i = 1'b0;
   logic [DW-1:0] cfg_div_i = '0;
   logic [1:0]    start_i = '0;
   logic [1:0]    stop_i = '0;
   logic          sw_clk_1_o, sw_clk_2_o, sw_en_1_o, sw_en_2_o;
   logic [IW-1:0] idx_1_o, idx_2_o;
   logic [1:0]    busy_o, cycle_done_o;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: mode 0 idle, 1 run, 2 drain; ticks derived from the start edge number
   int     m_mode  [2];
   longint m_t0    [2];
   int     m_div   [2];
   bit     m_pulse [2];
   int     m_count [2];
   bit     m_done  [2];
   bit     m_busy  [2];
   longint m_t;

   sine_channel_scheduler #(.DIV_WIDTH(DW), .IDX_WIDTH(IW)) dut (
      .sys_clk_i    (clk),
      .sys_rst_i    (rst_n),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .cfg_ch_i     (cfg_ch_i),
      .cfg_div_i    (cfg_div_i),
      .start_i      (start_i),
      .stop_i       (stop_i),
      .sw_clk_1_o   (sw_clk_1_o),
      .sw_clk_2_o   (sw_clk_2_o),
      .sw_en_1_o    (sw_en_1_o),
      .sw_en_2_o    (sw_en_2_o),
      .idx_1_o      (idx_1_o),
      .idx_2_o      (idx_2_o),
      .busy_o       (busy_o),
      .cycle_done_o (cycle_done_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_mode[c] = 0; m_t0[c] = 0; m_div[c] = 0; m_pulse[c] = 0;
         m_count[c] = 0; m_done[c] = 0; m_busy[c] = 0;
      end
   endtask

   task automatic model_step();
      m_t++;
      for (int c = 0; c < 2; c++) begin
         bit st, sp, was, wrap;
         int nm;
         st   = start_i[c];
         sp   = stop_i[c];
         was  = (m_mode[c] != 0);
         wrap = m_pulse[c] && (((m_count[c] + 1) % 256) == 0);
         nm   = m_mode[c];
         if (m_pulse[c]) m_count[c]++;
         if (cfg_valid_i && (int'(cfg_ch_i) == c) && m_mode[c] == 0) m_div[c] = int'(cfg_div_i);
         case (m_mode[c])
            0: if (st && !sp) begin nm = 1; m_t0[c] = m_t; end
            1: if (sp) nm = 2;
            default: if (st && !sp) nm = 1; else if (wrap) nm = 0;
         endcase
         m_pulse[c] = was && (nm != 0) && (((m_t - m_t0[c]) % longint'(m_div[c] + 1)) == 0);
         m_done[c]  = wrap;
         m_busy[c]  = was;
         m_mode[c]  = nm;
      end
   endtask

   task automatic compare_outputs();
      check_val("sw_clk_1", 32'(sw_clk_1_o), 32'(m_pulse[0]));
      check_val("sw_clk_2", 32'(sw_clk_2_o), 32'(m_pulse[1]));
      check_val("sw_en_1",  32'(sw_en_1_o),  32'(m_busy[0]));
      check_val("sw_en_2",  32'(sw_en_2_o),  32'(m_busy[1]));
      check_val("idx_1",    32'(idx_1_o),    32'(m_count[0] % 256));
      check_val("idx_2",    32'(idx_2_o),    32'(m_count[1] % 256));
      check_val("busy",     32'(busy_o),     32'({m_busy[1], m_busy[0]}));
      check_val("cycle_done", 32'(cycle_done_o), 32'({m_done[1], m_done[0]}));
   endtask

   // entered just after a falling-edge comparison; leaves at the next falling edge
   task automatic cycle(input logic [1:0] st, input logic [1:0] sp, input logic cv,
                        input logic cc, input logic [DW-1:0] cd);
      start_i = st; stop_i = sp; cfg_valid_i = cv; cfg_ch_i = cc; cfg_div_i = cd;
      #1;
      check_val("cfg_ready", 32'(cfg_ready_o), 32'(m_mode[cc] == 0));
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 1'b0, 1'b0, '0);
   endtask

   task automatic run_to_idx(input int c, input int target, input int limit);
      int n = 0;
      while ((m_count[c] % 256) != target && n < limit) begin
         idle_cycles(1);
         n++;
      end
      if (n >= limit) check_val("timeout_idx", 32'(m_count[c] % 256), 32'(target));
   endtask

   task automatic run_to_idle(input int c, input int limit);
      int n = 0;
      while (m_mode[c] != 0 && n < limit) begin
         idle_cycles(1);
         n++;
      end
      if (n >= limit) check_val("timeout_idle", 32'(m_mode[c]), 32'd0);
   endtask

   initial begin
      int n;
      m_t = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_outputs();
      check_val("ready_in_reset", 32'(cfg_ready_o), 32'd1);
      rst_n = 1'b1;

      // ch1 div=3 then start: ticks every 4 cycles, ch2 untouched
      cycle(2'b00, 2'b00, 1'b1, 1'b0, 16'd3);
      cycle(2'b01, 2'b00, 1'b0, 1'b0, '0);
      idle_cycles(20);
      check_val("ch2_idle", 32'(busy_o[1]), 32'd0);
      cycle(2'b00, 2'b01, 1'b0, 1'b0, '0);
      run_to_idle(0, 1200);

      // div=0, stop at idx 10, drain through wrap to idle
      cycle(2'b00, 2'b00, 1'b1, 1'b0, 16'd0);
      cycle(2'b01, 2'b00, 1'b0, 1'b0, '0);
      run_to_idx(0, 10, 400);
      cycle(2'b00, 2'b01, 1'b0, 1'b0, '0);
      run_to_idle(0, 400);
      idle_cycles(5);
      check_val("drain_end_idx", 32'(idx_1_o), 32'd0);
      check_val("drain_end_busy", 32'(busy_o[0]), 32'd0);

      // start during drain at idx 200 cancels the stop
      cycle(2'b01, 2'b00, 1'b0, 1'b0, '0);
      run_to_idx(0, 150, 400);
      cycle(2'b00, 2'b01, 1'b0, 1'b0, '0);
      run_to_idx(0, 200, 400);
      cycle(2'b01, 2'b00, 1'b0, 1'b0, '0);
      idle_cycles(300);
      check_val("drain_cancel_busy", 32'(busy_o[0]), 32'd1);

      // asynchronous reset between edges while running
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      check_val("ready_mid_reset", 32'(cfg_ready_o), 32'd1);
      @(negedge clk);
      compare_outputs();
      rst_n = 1'b1;

      // simultaneous start=11 stop=01 from idle
      cycle(2'b11, 2'b01, 1'b0, 1'b0, '0);
      idle_cycles(2);
      check_val("start11_stop01_busy", 32'(busy_o), 32'b10);

      // ch2 config blocked while running, accepted after drain completes
      cycle(2'b00, 2'b00, 1'b1, 1'b1, 16'd5);
      cycle(2'b00, 2'b10, 1'b1, 1'b1, 16'd5);
      n = 0;
      while (m_mode[1] != 0 && n < 600) begin
         cycle(2'b00, 2'b00, 1'b1, 1'b1, 16'd5);
         n++;
      end
      if (n >= 600) check_val("timeout_cfg", 32'(m_mode[1]), 32'd0);
      cycle(2'b00, 2'b00, 1'b1, 1'b1, 16'd5);
      cycle(2'b10, 2'b00, 1'b0, 1'b1, '0);
      idle_cycles(30);
      cycle(2'b00, 2'b10, 1'b0, 1'b1, '0);
      run_to_idle(1, 2000);

      // randomized traffic
      for (int i = 0; i < 5000; i++) begin
         logic [1:0] st, sp;
         st[0] = ($urandom_range(0, 59) == 0);
         st[1] = ($urandom_range(0, 59) == 0);
         sp[0] = ($urandom_range(0, 79) == 0);
         sp[1] = ($urandom_range(0, 79) == 0);
         cycle(st, sp, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               DW'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sine_channel_scheduler.md
SINE_CHANNEL_SCHEDULER -- requirements
Module: sine_channel_scheduler

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, the width of the per-channel sample-rate divider.
REQ-002 SHALL have parameter IDX_WIDTH, default 8, the width of the mirrored sine LUT index (256 entries).
REQ-003 SHALL have port sys_clk_i  in  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid_i  in  1  divider write request.
REQ-006 SHALL have port cfg_ready_o  out  1  divider write may be accepted.
REQ-007 SHALL have port cfg_ch_i  in  1  target channel of the write (0 = channel 1, 1 = channel 2).
REQ-008 SHALL have port cfg_div_i  in  DIV_WIDTH  divider value; the tick period is cfg_div_i+1 clocks.
REQ-009 SHALL have port start_i  in  2  per-channel start request (bit0 = ch1, bit1 = ch2).
REQ-010 SHALL have port stop_i  in  2  per-channel stop request.
REQ-011 SHALL have ports sw_clk_1_o and sw_clk_2_o  out  1 each  one-cycle waveform advance pulses.
REQ-012 SHALL have ports sw_en_1_o and sw_en_2_o  out  1 each  waveform output enables.
REQ-013 SHALL have ports idx_1_o and idx_2_o  out  IDX_WIDTH each  mirrored LUT index per channel.
REQ-014 SHALL have port busy_o  out  2  per-channel state is not IDLE.
REQ-015 SHALL have port cycle_done_o  out  2  one-cycle pulse on each index wrap.

Function
REQ-016 SHALL run one independent FSM per channel with states IDLE, RUN and DRAIN.
REQ-017 SHALL hold, per channel, a divider register div, a prescaler of DIV_WIDTH bits and an index idx of IDX_WIDTH bits.
REQ-018 SHALL drive cfg_ready_o combinationally high exactly when the channel selected by cfg_ch_i is in IDLE.
REQ-019 SHALL load div[cfg_ch_i] from cfg_div_i on an edge where cfg_valid_i and cfg_ready_o are both high; otherwise div is unchanged.
REQ-020 SHALL handle IDLE as follows: start only -> RUN, with the prescaler cleared to 0 and idx held at 0; start and stop together -> remain IDLE.
REQ-021 SHALL handle RUN as follows: stop (with or without start) -> DRAIN; start alone is ignored.
REQ-022 SHALL handle DRAIN as follows: start without stop -> RUN (cancels the pending stop); stop alone, or start and stop together, -> remain in DRAIN.
REQ-023 SHALL, in RUN and DRAIN, increment the prescaler each clock and, when it equals div, reset it to 0 and register sw_clk_x_o high for the next cycle only.
REQ-024 SHALL produce the first sw_clk_x_o pulse in the (div+1)th cycle after the edge that sampled start_i; consecutive pulses SHALL be exactly div+1 cycles apart; div=0 gives a pulse every cycle.
REQ-025 SHALL increment idx on every edge that samples sw_clk_x_o high, wrapping from 2^IDX_WIDTH-1 to 0, which keeps idx equal to the downstream LUT counter.
REQ-026 SHALL register cycle_done_o[x] high for one cycle following each idx wrap.
REQ-027 SHALL, in DRAIN, on the edge where idx wraps to 0, enter IDLE and clear the prescaler, so every waveform ends at index 0 (mid-scale).
REQ-028 SHALL generate no sw_clk_x_o pulse in the cycle after a DRAIN->IDLE transition.
REQ-029 SHALL register sw_en_x_o and busy_o[x] high while the state is RUN or DRAIN, and low in IDLE, with one cycle of latency after the state change.
REQ-030 SHALL NOT let either channel's requests, divider or state affect the other channel.

Reset
REQ-031 SHALL, while sys_rst_i is low and independent of the clock, set both FSMs to IDLE and clear div, prescaler and idx to 0.
REQ-032 SHALL, while sys_rst_i is low, drive sw_clk_x_o=0, sw_en_x_o=0, busy_o=2'b00, cycle_done_o=2'b00 and idx_x_o=0.
REQ-033 SHALL abort any RUN or DRAIN state when reset asserts mid-operation, with no completion pulse.
REQ-034 SHALL leave cfg_ready_o combinational, so it reads 1 during reset.

Verification
REQ-035 SHALL cover: write ch1 div=3, pulse start_i=01 -> first sw_clk_1_o 4 cycles later, then every 4 cycles; sw_en_1_o high; channel 2 stays idle.
REQ-036 SHALL cover: with ch1 at div=0, stop at idx=10 -> DRAIN, 246 more pulses; idx wraps to 0; cycle_done_o[0] pulses; busy_o[0] drops; no further pulses.
REQ-037 SHALL cover: start during DRAIN at idx=200 -> returns to RUN with no stop at the wrap; pulses continue past idx 0.
REQ-038 SHALL cover: cfg_valid_i to ch2 while ch2 is in RUN -> cfg_ready_o=0 and the write is not taken; after ch2 reaches IDLE the write is accepted on the next edge.
REQ-039 SHALL cover: start_i=11 and stop_i=01 together from IDLE -> ch1 stays IDLE and ch2 enters RUN.
REQ-040 SHALL cover: sys_rst_i driven low between clock edges mid-RUN -> all outputs reach their reset values immediately; after release, start restarts from idx 0.
